// File: rtl/persephone_io_bridge.sv
// persephone_io_bridge: pin interface between the CPU core and the user pins.
// Synchronises and debounces the dedicated inputs, latches rising-edge events
// with a maskable interrupt, and drives the dedicated and bidirectional pins
// from CPU-writable registers. The bidirectional bank powers up as inputs.
module persephone_io_bridge #(
    parameter int W               = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] ui_in,
    input  logic [W-1:0] uio_in,
    output logic [W-1:0] uo_out,
    output logic [W-1:0] uio_out,
    output logic [W-1:0] uio_oe,
    output logic [W-1:0] sw,
    input  logic         cpu_wr_en,
    input  logic [2:0]   cpu_addr,
    input  logic [W-1:0] cpu_wr_data,
    output logic [W-1:0] cpu_rd_data,
    output logic         irq
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_UIO_OUT = 3'd1;
    localparam logic [2:0] ADDR_UIO_OE  = 3'd2;
    localparam logic [2:0] ADDR_EVT     = 3'd3;
    localparam logic [2:0] ADDR_MASK    = 3'd4;

    logic [W-1:0] ui_sync_q  [SYNC_STAGES];
    logic [W-1:0] ui_sync_d  [SYNC_STAGES];
    logic [W-1:0] uio_sync_q [SYNC_STAGES];
    logic [W-1:0] uio_sync_d [SYNC_STAGES];
    logic [W-1:0] ui_s;
    logic [W-1:0] uio_s;

    logic [W-1:0] sw_q, sw_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] uio_out_q, uio_out_d;
    logic [W-1:0] uio_oe_q, uio_oe_d;
    logic [W-1:0] evt_q, evt_d;
    logic [W-1:0] mask_q, mask_d;
    logic         irq_q, irq_d;
    logic [W-1:0] evt_clr;
    logic [W-1:0] sw_rise;

    // Synchroniser chains: each stage takes the previous stage's value.
    always_comb begin
        ui_sync_d[0]  = ui_in;
        uio_sync_d[0] = uio_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            ui_sync_d[k]  = ui_sync_q[k-1];
            uio_sync_d[k] = uio_sync_q[k-1];
        end
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                ui_sync_q[k]  <= '0;
                uio_sync_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                ui_sync_q[k]  <= ui_sync_d[k];
                uio_sync_q[k] <= uio_sync_d[k];
            end
        end
    end

    assign ui_s  = ui_sync_q[SYNC_STAGES-1];
    assign uio_s = uio_sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_deb
            localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [W];
            logic [CNT_W-1:0] cnt_d [W];

            // Per-bit debounce: count consecutive disagreeing cycles, flip at terminal count.
            always_comb begin
                sw_d = sw_q;
                for (int i = 0; i < W; i++) begin
                    cnt_d[i] = '0;
                    if (ui_s[i] != sw_q[i]) begin
                        if (cnt_q[i] == CNT_TC) begin
                            sw_d[i] = ui_s[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            // Debounce counters.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < W; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < W; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end
        end else begin : g_byp
            // Bypass: sw tracks the value the last sync stage is about to take,
            // so sw_q equals ui_s with no extra cycle.
            always_comb begin
                sw_d = ui_sync_d[SYNC_STAGES-1];
            end
        end
    endgenerate

    // CPU writes, event latching (set beats clear) and next interrupt level.
    always_comb begin
        out_d     = out_q;
        uio_out_d = uio_out_q;
        uio_oe_d  = uio_oe_q;
        mask_d    = mask_q;
        evt_clr   = '0;
        if (cpu_wr_en) begin
            case (cpu_addr)
                ADDR_OUT:     out_d     = cpu_wr_data;
                ADDR_UIO_OUT: uio_out_d = cpu_wr_data;
                ADDR_UIO_OE:  uio_oe_d  = cpu_wr_data;
                ADDR_EVT:     evt_clr   = cpu_wr_data;
                ADDR_MASK:    mask_d    = cpu_wr_data;
                default:      ;
            endcase
        end
        sw_rise = sw_d & ~sw_q;
        evt_d   = (evt_q & ~evt_clr) | sw_rise;
        irq_d   = |(evt_d & mask_d);
    end

    // Register state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_q      <= '0;
            out_q     <= '0;
            uio_out_q <= '0;
            uio_oe_q  <= '0;
            evt_q     <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            sw_q      <= sw_d;
            out_q     <= out_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
            evt_q     <= evt_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    // Read mux from current state; address 1 is the synchronised pad value.
    always_comb begin
        cpu_rd_data = '0;
        case (cpu_addr)
            3'd0:    cpu_rd_data = sw_q;
            3'd1:    cpu_rd_data = uio_s;
            3'd2:    cpu_rd_data = uio_oe_q;
            3'd3:    cpu_rd_data = evt_q;
            3'd4:    cpu_rd_data = mask_q;
            default: cpu_rd_data = '0;
        endcase
    end

    assign uo_out  = out_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;
    assign sw      = sw_q;
    assign irq     = irq_q;

endmodule

// File: doc/persephone_io_bridge.md
Name: persephone_io_bridge

Overview:
- Parametrised pin-interface block between the CPU core and the chip-level user pins; replaces direct wiring of switches and CPU output to pins.
- Synchronises and debounces the dedicated inputs, latches rising-edge events with an interrupt, and drives the dedicated and bidirectional pins from CPU-writable registers.
- Gives the CPU software control of the bidirectional bank, which the earlier top-level held permanently as inputs.

Parameters:
- W, 8, width of ui_in, uo_out, uio_* and all data registers.
- SYNC_STAGES, 2, synchroniser depth for ui_in and uio_in; legal values are 2 or more.
- DEBOUNCE_CYCLES, 4, number of consecutive disagreeing cycles before a debounced bit flips; 0 bypasses the debouncer.
- CNT_W, 3, width of each per-bit debounce counter; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- ui_in  input  W  raw dedicated input pins (switches).
- uio_in  input  W  raw bidirectional pin input path.
- uo_out  output  W  dedicated output pins, driven from register OUT.
- uio_out  output  W  bidirectional output path, driven from register UIO_OUT.
- uio_oe  output  W  bidirectional enables (1 = drive), driven from register UIO_OE.
- sw  output  W  debounced ui_in value presented to the CPU core.
- cpu_wr_en  input  1  write strobe, sampled on the rising edge.
- cpu_addr  input  3  register address, shared by reads and writes.
- cpu_wr_data  input  W  write data.
- cpu_rd_data  output  W  combinational read data.
- irq  output  1  registered interrupt, high when any (EVT & IRQ_MASK) bit is set.

Behaviour:
- Reset: synchronous; takes effect on any rising edge where rst_n = 0.
  - All synchroniser flops, debounced state, counters, OUT, UIO_OUT, UIO_OE, EVT, IRQ_MASK and irq go to 0.
  - After reset, uio_oe = 0, so all bidirectional pins are inputs.
  - Reset asserted mid-debounce discards partial counts.
- Synchronisers: ui_in and uio_in each pass through a SYNC_STAGES-deep flop chain, giving ui_s and uio_s.
- Debounce, per bit i, when DEBOUNCE_CYCLES > 0:
  - When ui_s[i] equals sw[i], cnt[i] is set to 0.
  - When they differ and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] increments.
  - When they differ and cnt[i] == DEBOUNCE_CYCLES-1, sw[i] takes ui_s[i] and cnt[i] is set to 0.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves sw unchanged.
- Debounce bypass: when DEBOUNCE_CYCLES = 0, sw = ui_s, registered with no additional latency.
- Input-to-sw latency: a clean ui_in step changes sw on rising edge SYNC_STAGES+DEBOUNCE_CYCLES after the step. With defaults this is edge 6.
- Register map, write behaviour (effective on the edge where cpu_wr_en = 1):
  - 0 OUT: written value appears on uo_out one cycle later.
  - 1 UIO_OUT: same timing, drives uio_out.
  - 2 UIO_OE: same timing, drives uio_oe.
  - 3 EVT: write-1-to-clear.
  - 4 IRQ_MASK: plain write.
  - 5–7: writes are ignored.
- Register map, read data (combinational, from current register state):
  - 0: returns sw.
  - 1: returns uio_s. This is the synchronised pad value, including bits the block itself drives.
  - 2: returns UIO_OE.
  - 3: returns EVT.
  - 4: returns IRQ_MASK.
  - 5–7: return 0.
- EVT[i] set: EVT[i] sets on the same edge that sw[i] transitions 0→1. A 1→0 transition does not set it.
- EVT[i] clear: writing a 1 to EVT[i] clears it. If a set and a clear hit the same bit on the same edge, the set wins and the bit stays 1.
- irq: on each edge, irq takes |(EVT_next & IRQ_MASK_next), so it changes on the same edge as the flags and mask that drive it.
  - Clearing the last masked flag drops irq on that edge.
  - Unmasking an already-set flag raises irq on that edge.
- Ordering: no read/write hazard. A read in the same cycle as a write to the same address returns the pre-write value.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with ui_in = 8'hFF, then release -> uo_out, uio_out, uio_oe, sw, irq are all 0 and every register reads 0.
- Clean input: ui_in steps 8'h00 -> 8'h05 before edge 1, defaults -> sw = 8'h05 from edge 6 (not before), EVT reads 8'h05, irq stays 0 because IRQ_MASK = 0.
- Glitch rejection: ui_in[0] pulses high for 3 clocks -> sw[0] stays 0 and EVT[0] stays 0. A pulse of 6 or more clocks -> sw[0] = 1.
- IRQ and W1C race: IRQ_MASK = 8'h01, EVT[0] set -> irq = 1. Write EVT = 8'h01 -> irq = 0 the next cycle. A W1C on the exact edge of a new rising edge leaves EVT[0] = 1 and irq = 1.
- Bidirectional bank: write UIO_OE = 8'hF0 and UIO_OUT = 8'hA5, drive uio_in = 8'h3C -> uio_oe = 8'hF0 and uio_out = 8'hA5 the cycle after each write, and address 1 reads 8'h3C after SYNC_STAGES cycles.
- Reserved addresses and bypass: a write to address 6 changes no register and reads of addresses 5–7 return 0. With DEBOUNCE_CYCLES = 0, an ui_in step reaches sw on edge 2.
